// File: rtl/imem_loader.sv
// Instruction memory loader: parses a 2-byte word count, then writes little-endian
// 32-bit words to the imem write port. Optional checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // HDR0  | expecting word-count low byte
  // HDR1  | expecting word-count high byte, range check
  // DATA  | collecting 4 bytes per word, writing memory
  // CSUM  | expecting checksum byte (checksum build only)
  // DONE  | image loaded, CPU released
  // ERR   | load aborted, CPU held
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CSUM;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  localparam int CW = ADDR_W + 1;

  state_t          state_q, state_d;
  logic [7:0]      count_lo_q;
  logic [CW-1:0]   count_q;
  logic [1:0]      byte_idx_q;
  logic [23:0]     shift_q;
  logic            xfer;
  logic            load_start;
  logic [15:0]     hdr_count;
  logic [31:0]     hdr_span;
  logic            hdr_bad;
  logic            last_word_pending;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  assign xfer       = in_valid && in_ready;
  assign load_start = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign hdr_count  = {in_byte, count_lo_q};
  // Anything that would run past the end of memory (including address wrap) is rejected.
  assign hdr_span   = 32'(hdr_count) + 32'(START_ADDR);
  assign hdr_bad    = hdr_span > 32'(DEPTH);
  // While the final word's write pulse is out, stop taking bytes so nothing extra is consumed.
  assign last_word_pending = mem_we && ((words_written + CW'(1)) == count_q);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) state_d = S_HDR0;
      end
      S_HDR0: begin
        in_ready = 1'b1;
        if (xfer) state_d = S_HDR1;
      end
      S_HDR1: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (hdr_count == 16'd0) state_d = S_FINISH;
          else if (hdr_bad)       state_d = S_ERR;
          else                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = !last_word_pending;
        if (last_word_pending) state_d = S_FINISH;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        if (xfer) state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        if (load_start) state_d = S_HDR0;
      end
      S_ERR: begin
        if (load_start) state_d = S_HDR0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      count_lo_q    <= '0;
      count_q       <= '0;
      byte_idx_q    <= '0;
      shift_q       <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= ADDR_W'(START_ADDR);
      mem_din       <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      state_q  <= state_d;
      mem_we   <= 1'b0;
      done     <= (state_d == S_DONE);
      error    <= (state_d == S_ERR);
      cpu_hold <= (state_d != S_DONE);

      if (load_start) begin
        words_written <= '0;
        byte_idx_q    <= '0;
      end

      if (mem_we) begin
        mem_addr      <= mem_addr + ADDR_W'(1);
        words_written <= words_written + CW'(1);
      end

      if (xfer) begin
        unique case (state_q)
          S_HDR0: count_lo_q <= in_byte;
          S_HDR1: begin
            count_q    <= hdr_count[CW-1:0];
            mem_addr   <= ADDR_W'(START_ADDR);
            byte_idx_q <= '0;
          end
          S_DATA: begin
            if (byte_idx_q == 2'd3) begin
              mem_we  <= 1'b1;
              mem_din <= {in_byte, shift_q};
            end else begin
              shift_q <= {in_byte, shift_q[23:8]};
            end
            byte_idx_q <= byte_idx_q + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else if (load_start) begin
      csum_q <= '0;
    end else if (xfer && state_q != S_CSUM) begin
      csum_q <= csum_q ^ in_byte;
    end
  end
`endif

endmodule
